disp_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a common-anode multi-digit 7-segment display. It shares one hex-to-7-segment decoder across NUM_DIGITS digits. Each scan slot drives one digit's anode, with dead time between slots to prevent ghosting. It double-buffers the displayed value, suppresses leading zeros, and supports blanking and blinking. It sits between game/score logic and the board's segment/anode pins.

---
 rtl/disp_pkg.sv | 10 +
 rtl/disp_scan_ctrl_if.sv | 13 +
 rtl/hex7seg.sv | 11 +
 rtl/disp_scan_ctrl.sv | 83 ++++++++
 tb/tb_disp_scan_ctrl.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/disp_pkg.sv
// disp_pkg: shared constants and sizing helpers for the display scan controller
package disp_pkg;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  function automatic logic [7:0] an_off(int n);
    return 8'((1 << n) - 1);
  endfunction
  function automatic int idx_w(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/disp_scan_ctrl_if.sv
// disp_scan_ctrl_if: value/control inputs and segment/anode pins of the scan controller
//   value_in/load/lz_en/blank_mask/blink_en/dp_mask : driven by game logic (master)
//   seg/dp/an/frame_done                             : driven by the controller (slave)
interface disp_scan_ctrl_if #(parameter int NUM_DIGITS = 4);
  logic [4*NUM_DIGITS-1:0] value_in;
  logic load, lz_en, blink_en, dp, frame_done;
  logic [NUM_DIGITS-1:0] blank_mask, dp_mask, an;
  logic [6:0] seg;
  modport master(output value_in, load, lz_en, blank_mask, blink_en, dp_mask,
                 input seg, dp, an, frame_done);
  modport slave(input value_in, load, lz_en, blank_mask, blink_en, dp_mask,
                output seg, dp, an, frame_done);
endinterface

// File: rtl/hex7seg.sv
// hex7seg: hex nibble to active-low 7-segment glyph (seg_o[0]=a .. seg_o[6]=g)
//   nib_i : hex digit in, seg_o : segment pattern out
module hex7seg (
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);
  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  assign seg_o = GLYPH[nib_i];
endmodule

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: time-multiplexed common-anode 7-segment scan with dead time, double buffer, LZ suppression, blanking and blink
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of disp_scan_ctrl_if (value/control in, seg/dp/an/frame_done out)
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int DEAD_CYCLES  = 500,
  parameter int BLINK_FRAMES = 32
) (
  input  logic clk,
  input  logic rst_n,
  disp_scan_ctrl_if.slave bus
);
  localparam int IW = idx_w(NUM_DIGITS);
  localparam int CW = idx_w(REFRESH_DIV);
  localparam int BW = idx_w(BLINK_FRAMES);
  localparam logic [NUM_DIGITS-1:0] AN_IDLE = NUM_DIGITS'(an_off(NUM_DIGITS));
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [BW-1:0] bc_q, bc_d;
  logic [4*NUM_DIGITS-1:0] pend_q, pend_d, disp_q, disp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0] seg_q, seg_d, glyph;
  logic [3:0] nib;
  logic pv_q, pv_d, ph_q, ph_d, dp_q, dp_d, fd_q, fd_d;
  logic wrap, last, bnd, bwrap, active, dark, supp;
  hex7seg u_dec (.nib_i(nib), .seg_o(glyph));
  always_comb begin
    wrap   = cnt_q == CW'(REFRESH_DIV - 1);
    last   = idx_q == IW'(NUM_DIGITS - 1);
    bnd    = wrap & last;
    bwrap  = bc_q == BW'(BLINK_FRAMES - 1);
    cnt_d  = wrap ? '0 : cnt_q + CW'(1);
    idx_d  = !wrap ? idx_q : last ? '0 : idx_q + IW'(1);
    pend_d = bus.load ? bus.value_in : pend_q;
    pv_d   = !bnd & (bus.load | pv_q);
    // a load landing on the boundary cycle bypasses pending and shows in the new frame
    disp_d = !bnd ? disp_q : bus.load ? bus.value_in : pv_q ? pend_q : disp_q;
    bc_d   = !bus.blink_en ? '0 : !bnd ? bc_q : bwrap ? '0 : bc_q + BW'(1);
    ph_d   = bus.blink_en & (ph_q ^ (bnd & bwrap));
    nib    = disp_q[{idx_q, 2'b00} +: 4];
    // suppressed when this nibble and every more significant one are zero
    supp   = bus.lz_en && idx_q != '0 && (disp_q >> {idx_q, 2'b00}) == '0;
    dark   = bus.blank_mask[idx_q] | supp | (bus.blink_en & ph_q);
    active = cnt_q >= CW'(DEAD_CYCLES);
    an_d   = active ? ~(NUM_DIGITS'(1) << idx_q) : AN_IDLE;
    seg_d  = active && !dark ? glyph : SEG_BLANK;
    dp_d   = !active || dark || !bus.dp_mask[idx_q];
    fd_d   = bnd;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      bc_q   <= '0;
      pend_q <= '0;
      disp_q <= '0;
      pv_q   <= 1'b0;
      ph_q   <= 1'b0;
      an_q   <= AN_IDLE;
      seg_q  <= SEG_BLANK;
      dp_q   <= 1'b1;
      fd_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      bc_q   <= bc_d;
      pend_q <= pend_d;
      disp_q <= disp_d;
      pv_q   <= pv_d;
      ph_q   <= ph_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      fd_q   <= fd_d;
    end
  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb_disp_scan_ctrl: scan-position model checked every cycle plus hand-computed pin expectations
module tb_disp_scan_ctrl;
  localparam int ND = 4, RD = 8, DC = 2, BF = 2, FR = RD * ND;
  localparam logic [6:0] GLY [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  typedef struct packed {
    logic [1:0] ep;
    logic [9:0] pos;
    logic [3:0] an;
    logic [6:0] seg;
    logic dp;
    logic fd;
  } lit_t;
  logic clk = 1'b0, rst_n = 1'b1;
  disp_scan_ctrl_if #(.NUM_DIGITS(ND)) bus();
  disp_scan_ctrl #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .DEAD_CYCLES(DC), .BLINK_FRAMES(BF))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  lit_t lits[$];
  int p = 0, ep = 0, run = 0, nv = 0, nerr = 0, cur, cyc, dig;
  logic in_rst = 1'b0, pv, bnd, dark, e_dp, e_fd;
  logic [15:0] disp, pl;
  logic [3:0] e_an;
  logic [6:0] e_seg;
  function automatic int P(int f, int d, int c);
    return f * FR + d * RD + c;
  endfunction
  function automatic void lit(int e, int pos, logic [3:0] an, logic [6:0] seg, logic dp, logic fd);
    lits.push_back(lit_t'{2'(e), 10'(pos), an, seg, dp, fd});
  endfunction
  // p = scan positions consumed since reset release; pins after an edge show position p-1
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p = 0; disp = '0; pl = '0; pv = 1'b0; run = 0; in_rst = 1'b1;
      #1;
      nv++;
      if (bus.an !== 4'hF || bus.seg !== 7'h7F || bus.dp !== 1'b1 || bus.frame_done !== 1'b0) begin
        nerr++;
        $display("FAIL reset: an=%b seg=%h dp=%b fd=%b, required an=1111 seg=7f dp=1 fd=0",
                 bus.an, bus.seg, bus.dp, bus.frame_done);
      end
    end else begin
      if (in_rst) begin ep++; in_rst = 1'b0; end
      cur = p;
      cyc = p % RD;
      dig = (p / RD) % ND;
      bnd = (p % FR) == FR - 1;
      dark = bus.blank_mask[dig] | (bus.lz_en && dig != 0 && (disp >> (4 * dig)) == 0) |
             (bus.blink_en && ((run / BF) % 2 == 1));
      e_an  = cyc < DC ? 4'hF : ~(4'b0001 << dig);
      e_seg = (cyc < DC || dark) ? 7'h7F : GLY[disp[4*dig +: 4]];
      e_dp  = (cyc < DC || dark) ? 1'b1 : ~bus.dp_mask[dig];
      e_fd  = bnd;
      if (bus.load) begin pl = bus.value_in; pv = 1'b1; end
      if (bnd && pv) begin disp = pl; pv = 1'b0; end
      run = !bus.blink_en ? 0 : run + int'(bnd);
      p++;
      #1;
      nv++;
      if (bus.an !== e_an || bus.seg !== e_seg || bus.dp !== e_dp || bus.frame_done !== e_fd) begin
        nerr++;
        $display("FAIL model ep%0d pos%0d: an=%b seg=%h dp=%b fd=%b, required an=%b seg=%h dp=%b fd=%b",
                 ep, cur, bus.an, bus.seg, bus.dp, bus.frame_done, e_an, e_seg, e_dp, e_fd);
      end
      foreach (lits[i])
        if (lits[i].ep == 2'(ep) && lits[i].pos == 10'(cur)) begin
          nv++;
          if (bus.an !== lits[i].an || bus.seg !== lits[i].seg || bus.dp !== lits[i].dp ||
              bus.frame_done !== lits[i].fd) begin
            nerr++;
            $display("FAIL lit%0d ep%0d pos%0d: an=%b seg=%h dp=%b fd=%b, required an=%b seg=%h dp=%b fd=%b",
                     i, ep, cur, bus.an, bus.seg, bus.dp, bus.frame_done,
                     lits[i].an, lits[i].seg, lits[i].dp, lits[i].fd);
          end
        end
    end
  end
  task automatic goto(int pos);
    for (int i = 0; i < 5000 && p != pos + 1; i++) @(negedge clk);
    if (p != pos + 1) begin
      $display("FAIL goto: position %0d never reached, at %0d", pos, p);
      $fatal(1, "scan position stalled");
    end
  endtask
  task automatic load_val(logic [15:0] v);
    bus.value_in = v;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "timeout");
  end
  initial begin
    lit(1, P(0,0,2), 4'hE, 7'h40, 1, 0);
    lit(1, P(0,3,7), 4'h7, 7'h40, 1, 1);
    lit(1, P(1,0,2), 4'hE, 7'h0E, 1, 0);
    lit(1, P(1,1,0), 4'hF, 7'h7F, 1, 0);
    lit(1, P(1,1,1), 4'hF, 7'h7F, 1, 0);
    lit(1, P(1,1,5), 4'hD, 7'h08, 1, 0);
    lit(1, P(1,2,2), 4'hB, 7'h24, 1, 0);
    lit(1, P(1,3,7), 4'h7, 7'h79, 1, 1);
    lit(1, P(2,0,4), 4'hE, 7'h40, 1, 0);
    lit(1, P(2,1,4), 4'hD, 7'h78, 1, 0);
    lit(1, P(2,2,4), 4'hB, 7'h7F, 1, 0);
    lit(1, P(2,3,4), 4'h7, 7'h7F, 1, 0);
    lit(1, P(3,0,4), 4'hE, 7'h40, 1, 0);
    lit(1, P(3,1,4), 4'hD, 7'h7F, 1, 0);
    lit(1, P(3,2,6), 4'hB, 7'h40, 1, 0);
    lit(1, P(3,3,4), 4'h7, 7'h40, 1, 0);
    lit(1, P(4,0,3), 4'hE, 7'h24, 1, 0);
    lit(1, P(4,3,3), 4'h7, 7'h24, 1, 0);
    lit(1, P(5,0,2), 4'hE, 7'h00, 1, 0);
    lit(1, P(5,2,7), 4'hB, 7'h00, 1, 0);
    lit(1, P(6,1,2), 4'hD, 7'h00, 1, 0);
    lit(1, P(7,0,2), 4'hE, 7'h7F, 1, 0);
    lit(1, P(7,3,7), 4'h7, 7'h7F, 1, 1);
    lit(1, P(8,0,0), 4'hF, 7'h7F, 1, 0);
    lit(1, P(8,2,5), 4'hB, 7'h7F, 1, 0);
    lit(1, P(8,3,7), 4'h7, 7'h7F, 1, 1);
    lit(1, P(9,0,2), 4'hE, 7'h00, 1, 0);
    lit(1, P(10,0,3), 4'hE, 7'h7F, 1, 0);
    lit(1, P(10,1,3), 4'hD, 7'h00, 1, 0);
    lit(1, P(10,2,1), 4'hF, 7'h7F, 1, 0);
    lit(1, P(10,2,3), 4'hB, 7'h00, 0, 0);
    lit(2, P(0,0,2), 4'hE, 7'h40, 1, 0);
    lit(2, P(0,2,3), 4'hB, 7'h40, 1, 0);
    bus.value_in = '0; bus.load = 0; bus.lz_en = 0; bus.blink_en = 0;
    bus.blank_mask = '0; bus.dp_mask = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    goto(P(0,0,3)); load_val(16'h12AF);
    goto(P(1,0,0)); bus.lz_en = 1;
    goto(P(1,0,3)); load_val(16'h0070);
    goto(P(2,0,5)); load_val(16'h0000);
    goto(P(3,1,5)); bus.lz_en = 0; load_val(16'h1111);
    goto(P(3,2,5)); load_val(16'h2222);
    goto(P(4,3,6)); load_val(16'h8888);
    goto(P(5,0,3)); bus.blink_en = 1;
    goto(P(9,1,0)); bus.blink_en = 0;
    goto(P(9,3,0)); bus.dp_mask = 4'b0100; bus.blank_mask = 4'b0001;
    goto(P(11,2,4)); rst_n = 1'b0; bus.dp_mask = '0; bus.blank_mask = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    goto(P(1,0,2));
    $display("== %0d vectors applied, %0d miscompares ==", nv, nerr);
    $finish;
  end
endmodule
